// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_sequencer
//  Description : Frame-level layer scheduler for a 20-layer detection network.
//                Starts each layer, waits for its done pulse under a
//                watchdog, steps through the layer configuration table and
//                flags detection-head completions and the end of a frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int unsigned           NUM_LAYERS = 20,
    parameter int unsigned           TIMEOUT_W  = 24,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT    = 24'hFFFFFF
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        frame_valid,
    output logic        frame_ready,
    output logic        layer_start,
    input  logic        layer_done,
    output logic [4:0]  layer_idx,
    output logic [1:0]  layer_kind,
    output logic [10:0] out_ch,
    output logic [4:0]  route_sel,
    output logic        concat_en,
    output logic        head_valid,
    output logic        head_id,
    output logic        frame_done,
    output logic        error
);

    localparam logic [4:0] c_last_idx = 5'(NUM_LAYERS - 1);
    localparam logic [4:0] c_head0    = 5'd15;
    localparam logic [4:0] c_head1    = 5'd19;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t                 r_state;
    logic [4:0]             r_layer_idx;
    logic [TIMEOUT_W-1:0]   r_wdog;
    logic                   r_error;
    logic                   r_frame_ready;
    logic                   r_layer_start;
    logic                   r_head_valid;
    logic                   r_head_id;
    logic                   r_frame_done;

    logic [TIMEOUT_W-1:0]   w_wdog_inc;
    logic                   w_is_head;

    // Watchdog increment saturates at all-ones so it can never wrap.
    assign w_wdog_inc = (r_wdog == {TIMEOUT_W{1'b1}}) ? r_wdog
                                                      : r_wdog + TIMEOUT_W'(1);
    assign w_is_head  = (r_layer_idx == c_head0) || (r_layer_idx == c_head1);

    // Sequencer FSM; every pulse output is registered on the transition into
    // the state that owns it, so pulses are clean one-cycle flops.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state       <= S_IDLE;
            r_layer_idx   <= 5'd0;
            r_wdog        <= '0;
            r_error       <= 1'b0;
            r_frame_ready <= 1'b1;
            r_layer_start <= 1'b0;
            r_head_valid  <= 1'b0;
            r_head_id     <= 1'b0;
            r_frame_done  <= 1'b0;
        end else begin
            r_layer_start <= 1'b0;
            r_head_valid  <= 1'b0;
            r_head_id     <= 1'b0;
            r_frame_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_valid && r_frame_ready) begin
                        r_layer_idx   <= 5'd0;
                        r_frame_ready <= 1'b0;
                        r_layer_start <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_START: begin
                    r_wdog  <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A done pulse on the timeout cycle still counts as done.
                    if (layer_done) begin
                        r_head_valid <= w_is_head;
                        r_head_id    <= (r_layer_idx == c_head1);
                        r_frame_done <= (r_layer_idx == c_last_idx);
                        r_state      <= S_NEXT;
                    end else if (w_wdog_inc >= TIMEOUT) begin
                        r_wdog  <= w_wdog_inc;
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_wdog <= w_wdog_inc;
                    end
                end
                S_NEXT: begin
                    if (r_layer_idx == c_last_idx) begin
                        r_frame_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_layer_idx   <= r_layer_idx + 5'd1;
                        r_layer_start <= 1'b1;
                        r_state       <= S_START;
                    end
                end
                S_ERR: begin
                    // Locked until reset; no pulses, not ready.
                    r_state <= S_ERR;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_frame_ready <= 1'b1;
                end
            endcase
        end
    end

    // Per-layer configuration table decoded from the current layer index.
    always_comb begin
        out_ch     = 11'd0;
        layer_kind = 2'd0;
        route_sel  = (r_layer_idx == 5'd0) ? 5'd0 : r_layer_idx - 5'd1;
        concat_en  = 1'b0;
        case (r_layer_idx)
            5'd0, 5'd1:   out_ch = 11'd16;
            5'd2, 5'd3:   out_ch = 11'd32;
            5'd4, 5'd5:   out_ch = 11'd64;
            5'd6, 5'd7:   out_ch = 11'd128;
            5'd8, 5'd9:   out_ch = 11'd256;
            5'd10, 5'd11: out_ch = 11'd512;
            5'd12:        out_ch = 11'd1024;
            5'd13:        out_ch = 11'd256;
            5'd14:        out_ch = 11'd512;
            5'd15:        out_ch = 11'd255;
            5'd16, 5'd17: out_ch = 11'd128;
            5'd18:        out_ch = 11'd256;
            5'd19:        out_ch = 11'd255;
            default:      out_ch = 11'd0;
        endcase
        case (r_layer_idx)
            5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11: layer_kind = 2'd1;
            5'd17:                               layer_kind = 2'd2;
            default:                             layer_kind = 2'd0;
        endcase
        // Layer 16 taps the layer-13 feature map; layer 18 concatenates the
        // upsampled layer 17 with layer 8.
        if (r_layer_idx == 5'd16) begin
            route_sel = 5'd13;
        end else if (r_layer_idx == 5'd18) begin
            route_sel = 5'd17;
            concat_en = 1'b1;
        end
    end

    assign frame_ready = r_frame_ready;
    assign layer_start = r_layer_start;
    assign layer_idx   = r_layer_idx;
    assign head_valid  = r_head_valid;
    assign head_id     = r_head_id;
    assign frame_done  = r_frame_done;
    assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_layer_sequencer
//  Description : Self-checking bench for layer_sequencer with an event
//                scoreboard for layer_start / head_valid / frame_done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;

    localparam logic [1:0] EV_START = 2'd0;
    localparam logic [1:0] EV_HEAD  = 2'd1;
    localparam logic [1:0] EV_FDONE = 2'd2;

    logic        Clk;
    logic        Rst;
    logic        frame_valid;
    logic        frame_ready;
    logic        layer_start;
    logic        layer_done;
    logic [4:0]  layer_idx;
    logic [1:0]  layer_kind;
    logic [10:0] out_ch;
    logic [4:0]  route_sel;
    logic        concat_en;
    logic        head_valid;
    logic        head_id;
    logic        frame_done;
    logic        error;

    int n_checks = 0;
    int n_errors = 0;
    int n_start  = 0;
    int n_head   = 0;
    int n_fdone  = 0;

    logic [6:0] sb[$];   // {kind, idx}

    layer_sequencer #(
        .NUM_LAYERS (20),
        .TIMEOUT_W  (24),
        .TIMEOUT    (24'd8)
    ) u_dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .layer_start (layer_start),
        .layer_done  (layer_done),
        .layer_idx   (layer_idx),
        .layer_kind  (layer_kind),
        .out_ch      (out_ch),
        .route_sel   (route_sel),
        .concat_en   (concat_en),
        .head_valid  (head_valid),
        .head_id     (head_id),
        .frame_done  (frame_done),
        .error       (error)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: got time limit expected finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference configuration table.
    function automatic int exp_ch(input int idx);
        int t[20] = '{16, 16, 32, 32, 64, 64, 128, 128, 256, 256,
                      512, 512, 1024, 256, 512, 255, 128, 128, 256, 255};
        return t[idx];
    endfunction

    function automatic int exp_kind(input int idx);
        if (idx == 17) return 2;
        if (idx <= 11 && (idx % 2) == 1) return 1;
        return 0;
    endfunction

    function automatic int exp_route(input int idx);
        if (idx == 16) return 13;
        if (idx == 18) return 17;
        if (idx == 0) return 0;
        return idx - 1;
    endfunction

    task automatic sb_expect(input logic [1:0] kind, input logic [4:0] idx);
        logic [6:0] e;
        if (sb.size() == 0) begin
            check_val("sb_unexpected_pulse", 32'(kind), 32'd3);
        end else begin
            e = sb.pop_front();
            check_val("sb_kind", 32'(kind), 32'(e[6:5]));
            check_val("sb_idx", 32'(idx), 32'(e[4:0]));
            if (kind == EV_START) begin
                check_val("cfg_out_ch", 32'(out_ch), exp_ch(int'(e[4:0])));
                check_val("cfg_kind", 32'(layer_kind), exp_kind(int'(e[4:0])));
                check_val("cfg_route", 32'(route_sel), exp_route(int'(e[4:0])));
                check_val("cfg_concat", 32'(concat_en), (e[4:0] == 5'd18) ? 32'd1 : 32'd0);
            end
        end
    endtask

    // Scoreboard monitor: every output pulse must match the next expected event.
    always @(negedge Clk) begin
        if (head_valid === 1'b1) begin
            n_head++;
            sb_expect(EV_HEAD, {4'd0, head_id});
        end
        if (frame_done === 1'b1) begin
            n_fdone++;
            sb_expect(EV_FDONE, 5'd0);
        end
        if (layer_start === 1'b1) begin
            n_start++;
            sb_expect(EV_START, layer_idx);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_ready"}, 32'(frame_ready), 32'd1);
        check_val({tag, "_start"}, 32'(layer_start), 32'd0);
        check_val({tag, "_head"}, 32'(head_valid), 32'd0);
        check_val({tag, "_head_id"}, 32'(head_id), 32'd0);
        check_val({tag, "_fdone"}, 32'(frame_done), 32'd0);
        check_val({tag, "_error"}, 32'(error), 32'd0);
        check_val({tag, "_idx"}, 32'(layer_idx), 32'd0);
        check_val({tag, "_out_ch"}, 32'(out_ch), 32'd16);
        check_val({tag, "_kind"}, 32'(layer_kind), 32'd0);
        check_val({tag, "_route"}, 32'(route_sel), 32'd0);
        check_val({tag, "_concat"}, 32'(concat_en), 32'd0);
    endtask

    // Handshake a frame; returns in the cycle where layer 0 should start.
    task automatic frame_handshake();
        check_val("hs_ready", 32'(frame_ready), 32'd1);
        frame_valid = 1'b1;
        sb.push_back({EV_START, 5'd0});
        tick();
        frame_valid = 1'b0;
    endtask

    // Entered in the layer_start cycle; completes the layer after 'delay'
    // cycles and returns in the next layer_start cycle (or the IDLE cycle).
    task automatic run_layer(input int idx, input int delay, input bit spurious);
        check_val("start_pulse", 32'(layer_start), 32'd1);
        check_val("start_idx", 32'(layer_idx), 32'(idx));
        if (spurious) begin
            layer_done  = 1'b1;
            frame_valid = 1'b1;
        end
        tick();
        layer_done  = 1'b0;
        frame_valid = 1'b0;
        check_val("start_one_cycle", 32'(layer_start), 32'd0);
        check_val("wait_idx", 32'(layer_idx), 32'(idx));
        for (int i = 1; i < delay; i++) tick();
        check_val("wait_no_error", 32'(error), 32'd0);
        layer_done = 1'b1;
        if (idx == 15) sb.push_back({EV_HEAD, 5'd0});
        if (idx == 19) sb.push_back({EV_HEAD, 5'd1});
        if (idx == 19) sb.push_back({EV_FDONE, 5'd0});
        else           sb.push_back({EV_START, 5'(idx + 1)});
        tick();
        layer_done = 1'b0;
        check_val("next_head_valid", 32'(head_valid), (idx == 15 || idx == 19) ? 32'd1 : 32'd0);
        check_val("next_head_id", 32'(head_id), (idx == 19) ? 32'd1 : 32'd0);
        check_val("next_frame_done", 32'(frame_done), (idx == 19) ? 32'd1 : 32'd0);
        check_val("next_no_start", 32'(layer_start), 32'd0);
        check_val("next_no_error", 32'(error), 32'd0);
        tick();
        if (idx == 19) begin
            check_val("end_ready", 32'(frame_ready), 32'd1);
            check_val("end_no_start", 32'(layer_start), 32'd0);
        end
    endtask

    initial begin
        int s0, h0, f0;
        Rst         = 1'b1;
        frame_valid = 1'b0;
        layer_done  = 1'b0;
        tick();
        tick();
        check_idle("rst");
        Rst = 1'b0;
        tick();
        check_idle("post_rst");

        // Spurious layer_done in IDLE.
        s0 = n_start;
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        tick();
        check_idle("idle_spurious");
        check_val("idle_spurious_starts", 32'(n_start), 32'(s0));

        // Full frame, done 5 cycles after each start; spurious inputs in START.
        s0 = n_start; h0 = n_head; f0 = n_fdone;
        frame_handshake();
        for (int l = 0; l < 20; l++) run_layer(l, 5, (l % 4) == 1);
        check_val("frame_starts", 32'(n_start - s0), 32'd20);
        check_val("frame_heads", 32'(n_head - h0), 32'd2);
        check_val("frame_dones", 32'(n_fdone - f0), 32'd1);
        tick();
        check_val("idle_after_frame", 32'(frame_ready), 32'd1);

        // Done exactly on the timeout cycle, then reset during WAIT of layer 10.
        frame_handshake();
        run_layer(0, 8, 1'b0);
        check_val("exact_timeout_error", 32'(error), 32'd0);
        for (int l = 1; l < 10; l++) run_layer(l, 1 + (l % 3), 1'b0);
        check_val("l10_start", 32'(layer_start), 32'd1);
        check_val("l10_idx", 32'(layer_idx), 32'd10);
        tick();
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_idle("mid_rst");
        tick();
        check_idle("mid_rst_idle");

        // New frame restarts at layer 0; layer 3 then times out.
        frame_handshake();
        for (int l = 0; l < 3; l++) run_layer(l, 2, 1'b0);
        check_val("l3_idx", 32'(layer_idx), 32'd3);
        for (int i = 0; i < 8; i++) tick();
        check_val("to_not_yet", 32'(error), 32'd0);
        tick();
        check_val("to_error", 32'(error), 32'd1);
        check_val("to_ready", 32'(frame_ready), 32'd0);
        s0 = n_start; h0 = n_head; f0 = n_fdone;
        for (int i = 0; i < 6; i++) begin
            layer_done  = (i % 2) == 0;
            frame_valid = 1'b1;
            tick();
        end
        layer_done  = 1'b0;
        frame_valid = 1'b0;
        tick();
        check_val("err_sticky", 32'(error), 32'd1);
        check_val("err_ready", 32'(frame_ready), 32'd0);
        check_val("err_idx", 32'(layer_idx), 32'd3);
        check_val("err_no_pulses", 32'(n_start - s0 + n_head - h0 + n_fdone - f0), 32'd0);

        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check_idle("err_rst");
        tick();
        check_val("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 20, number of layer steps per frame.
REQ-002 Parameter TIMEOUT_W, default 24, width of the per-layer watchdog counter.
REQ-003 Parameter TIMEOUT, default 24'hFFFFFF, cycles allowed between layer_start and layer_done.
REQ-004 Clk  input  1  single clock; all state changes on the rising edge.
REQ-005 Rst  input  1  reset; synchronous and active-high.
REQ-006 frame_valid  input  1  a new input frame is available.
REQ-007 frame_ready  output  1  sequencer accepts a frame; a frame is taken when frame_valid && frame_ready.
REQ-008 layer_start  output  1  one-cycle pulse starting the layer on layer_idx.
REQ-009 layer_done  input  1  one-cycle pulse from the active layer when it finishes.
REQ-010 layer_idx  output  5  index of the current layer, 0..NUM_LAYERS-1.
REQ-011 layer_kind  output  2  0 conv, 1 maxpool, 2 upsample, 3 reserved.
REQ-012 out_ch  output  11  output channel count of the current layer.
REQ-013 route_sel  output  5  source layer for the layer input; equals layer_idx-1 unless routed.
REQ-014 concat_en  output  1  layer input is a concatenation of route_sel and layer 8.
REQ-015 head_valid  output  1  one-cycle pulse when a detection-head layer completes.
REQ-016 head_id  output  1  0 for the head at layer 15, 1 for the head at layer 19.
REQ-017 frame_done  output  1  one-cycle pulse after the last layer completes.
REQ-018 error  output  1  sticky watchdog-timeout flag.

Function
REQ-019 States: IDLE, START, WAIT, NEXT, ERR; encoding is free.
REQ-020 In IDLE, frame_ready=1; on handshake, layer_idx<=0 and the FSM goes to START.
REQ-021 START lasts one cycle and drives layer_start=1, clears the watchdog, then goes to WAIT.
REQ-022 WAIT holds layer_idx and the config, and increments the watchdog each cycle.
REQ-023 If layer_done arrives in WAIT, the FSM goes to NEXT.
REQ-024 If the watchdog reaches TIMEOUT in WAIT with no layer_done, the FSM goes to ERR and sets error=1.
REQ-025 If layer_done and the timeout occur in the same cycle, layer_done wins.
REQ-026 NEXT lasts one cycle. If layer_idx==NUM_LAYERS-1: pulse frame_done and go to IDLE. Otherwise layer_idx+1 and go to START.
REQ-027 In NEXT, head_valid=1 when the finished layer_idx is 15 (head_id=0) or 19 (head_id=1).
REQ-028 A layer_done seen outside WAIT is ignored.
REQ-029 A frame_valid seen outside IDLE is ignored; frame_ready=0 outside IDLE.
REQ-030 ERR holds until Rst; in ERR, frame_ready=0 and no pulses are issued.
REQ-031 Config table, combinational from layer_idx, with out_ch per layer 0..19: 16,16,32,32,64,64,128,128,256,256,512,512,1024,256,512,255,128,128,256,255.
REQ-032 layer_kind per layer: layers 1,3,5,7,9,11 = maxpool; layer 17 = upsample; all others = conv.
REQ-033 Routing: layer 16 has route_sel=13; layer 18 has route_sel=17 and concat_en=1; every other layer has route_sel=layer_idx-1 (0 for layer 0) and concat_en=0.
REQ-034 Latency is fixed:
- frame handshake to layer_start: 1 cycle;
- layer_done to the next layer_start: 2 cycles;
- final layer_done to frame_done: 1 cycle.
REQ-035 The watchdog saturates and never wraps.

Reset
REQ-036 Rst forces IDLE from any state, including mid-frame and ERR.
REQ-037 Rst clears layer_idx=0, the watchdog, and error=0.
REQ-038 During Rst and the following IDLE cycle: frame_ready=1; layer_start=0, head_valid=0, head_id=0, frame_done=0.
REQ-039 Config outputs always reflect layer_idx; out of reset they show layer 0 (kind 0, out_ch 16, route_sel 0, concat_en 0).

Verification
REQ-040 Full frame, layer_done 5 cycles after each layer_start:
- 20 layer_start pulses;
- head_valid at layer 15 (id 0) and layer 19 (id 1);
- one frame_done;
- then frame_ready=1.
REQ-041 Timeout with TIMEOUT=8 and no layer_done after layer 3 starts:
- error=1, FSM in ERR, frame_ready=0;
- further layer_done and frame_valid have no effect.
REQ-042 Routing check, stepping to layers 16, 17 and 18:
- layer 16: route_sel=13, concat_en=0;
- layer 17: layer_kind=2;
- layer 18: route_sel=17, concat_en=1, out_ch=256.
REQ-043 Spurious layer_done in IDLE and START, plus frame_valid mid-frame: layer_idx and the pulse counts are unchanged.
REQ-044 Rst asserted during WAIT of layer 10: the next cycle is IDLE with layer_idx=0 and frame_ready=1; a new frame restarts at layer 0.
REQ-045 layer_done on the exact timeout cycle: the FSM goes to NEXT, error stays 0.
